// File: rtl/dlsc_div32_arb.sv
// Round-robin front end that shares one iterative 32-bit divider between several clients.
// Zero divisors are answered locally; every other request is forwarded and its result routed back to its owner.
module dlsc_div32_arb #(
    parameter int REQUESTERS = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [REQUESTERS-1:0]   in_valid,
    output logic [REQUESTERS-1:0]   in_ready,
    input  logic [32*REQUESTERS-1:0] in_dividend,
    input  logic [32*REQUESTERS-1:0] in_divisor,
    input  logic [REQUESTERS-1:0]   in_sign,
    output logic [REQUESTERS-1:0]   out_valid,
    input  logic [REQUESTERS-1:0]   out_ready,
    output logic [31:0]             out_quotient,
    output logic [31:0]             out_remainder,
    output logic                    busy,
    output logic [31:0]             div_dividend,
    output logic [31:0]             div_divisor,
    output logic                    div_sign,
    output logic                    div_start,
    input  logic                    div_done,
    input  logic [31:0]             div_quotient,
    input  logic [31:0]             div_remainder
);

    localparam int IDB = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_WAIT1,
        ST_WAIT,
        ST_ZERO,
        ST_RESP
    } state_t;

    state_t                  state_q;
    logic [IDB-1:0]          last_q;
    logic [IDB-1:0]          owner_q;
    logic [31:0]             dividend_q;
    logic [31:0]             divisor_q;
    logic                    sign_q;
    logic [31:0]             quot_q;
    logic [31:0]             rem_q;
    logic                    busy_q;
    logic                    div_start_q;
    logic [REQUESTERS-1:0]   out_valid_q;

    logic                    grant_found;
    logic [IDB-1:0]          grant_idx;
    logic [31:0]             grant_dividend;
    logic [31:0]             grant_divisor;
    logic                    grant_sign;
    logic [REQUESTERS-1:0]   owner_onehot;

    // Winner is the lowest valid index above the pointer, falling back to the lowest valid index overall.
    // NOTE: every signal written here gets a default first, so no path can leave one unassigned and infer a latch.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int i = REQUESTERS - 1; i >= 0; i--) begin
            if (in_valid[i]) begin
                grant_found = 1'b1;
                grant_idx   = IDB'(i);
            end
        end
        for (int i = REQUESTERS - 1; i >= 0; i--) begin
            if (in_valid[i] && (IDB'(i) > last_q)) begin
                grant_idx = IDB'(i);
            end
        end
    end

    assign grant_dividend = in_dividend[32*grant_idx +: 32];
    assign grant_divisor  = in_divisor[32*grant_idx +: 32];
    assign grant_sign     = in_sign[grant_idx];

    always_comb begin
        in_ready = '0;
        if (state_q == ST_IDLE && grant_found) begin
            in_ready[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        owner_onehot          = '0;
        owner_onehot[owner_q] = 1'b1;
    end

    // NOTE: the operand registers carry no reset; they are only consumed after an acceptance reloads them.
    always_ff @(posedge clk) begin
        if (state_q == ST_IDLE && grant_found) begin
            dividend_q <= grant_dividend;
            divisor_q  <= grant_divisor;
            sign_q     <= grant_sign;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            last_q      <= IDB'(REQUESTERS - 1);
            owner_q     <= '0;
            quot_q      <= '0;
            rem_q       <= '0;
            busy_q      <= 1'b0;
            div_start_q <= 1'b0;
            out_valid_q <= '0;
        end else begin
            div_start_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (grant_found) begin
                        owner_q <= grant_idx;
                        last_q  <= grant_idx;
                        busy_q  <= 1'b1;
                        if (grant_divisor == 32'd0) begin
                            state_q <= ST_ZERO;
                        end else begin
                            state_q     <= ST_START;
                            div_start_q <= 1'b1;
                        end
                    end
                end
                ST_START: state_q <= ST_WAIT1;
                // The divider's done flag may still be stale here, so it is not looked at yet.
                ST_WAIT1: state_q <= ST_WAIT;
                ST_WAIT: begin
                    if (div_done) begin
                        quot_q      <= div_quotient;
                        rem_q       <= div_remainder;
                        out_valid_q <= owner_onehot;
                        state_q     <= ST_RESP;
                    end
                end
                ST_ZERO: begin
                    quot_q      <= 32'hFFFF_FFFF;
                    rem_q       <= dividend_q;
                    out_valid_q <= owner_onehot;
                    state_q     <= ST_RESP;
                end
                ST_RESP: begin
                    if (out_ready[owner_q]) begin
                        out_valid_q <= '0;
                        busy_q      <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign out_valid     = out_valid_q;
    assign out_quotient  = quot_q;
    assign out_remainder = rem_q;
    assign busy          = busy_q;
    assign div_start     = div_start_q;
    assign div_dividend  = dividend_q;
    assign div_divisor   = divisor_q;
    assign div_sign      = sign_q;

endmodule

// File: tb/tb_dlsc_div32_arb.sv
// Randomised bench for dlsc_div32_arb: a divider stub plus a transaction-level model checked every cycle.
// Directed scenarios pin the model with hand-computed results before a long random run.
module tb_dlsc_div32_arb;

    localparam int N   = 4;
    localparam int INF = 32'h7fff_ffff;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [N-1:0]      in_valid;
    logic [N-1:0]      in_ready;
    logic [32*N-1:0]   in_dividend;
    logic [32*N-1:0]   in_divisor;
    logic [N-1:0]      in_sign;
    logic [N-1:0]      out_valid;
    logic [N-1:0]      out_ready;
    logic [31:0]       out_quotient;
    logic [31:0]       out_remainder;
    logic              busy;
    logic [31:0]       div_dividend;
    logic [31:0]       div_divisor;
    logic              div_sign;
    logic              div_start;
    logic              div_done;
    logic [31:0]       div_quotient;
    logic [31:0]       div_remainder;

    always #5 clk = ~clk;

    dlsc_div32_arb #(.REQUESTERS(N)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_dividend   (in_dividend),
        .in_divisor    (in_divisor),
        .in_sign       (in_sign),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_quotient  (out_quotient),
        .out_remainder (out_remainder),
        .busy          (busy),
        .div_dividend  (div_dividend),
        .div_divisor   (div_divisor),
        .div_sign      (div_sign),
        .div_start     (div_start),
        .div_done      (div_done),
        .div_quotient  (div_quotient),
        .div_remainder (div_remainder)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    // Client side
    bit          pend[N];
    logic [31:0] ca[N], cb[N];
    logic        cs[N];
    int          resp_cnt[N];
    logic [31:0] resp_q[N], resp_r[N];
    int          grants[$];
    int          start_cnt = 0;
    int          last_acc_cyc, last_resp_cyc;
    logic [N-1:0] rdy_mask = '1;
    bit          rdy_random = 1'b0;

    // Reference model: one outstanding operation described by timestamps
    bit          m_active, m_zero;
    int          m_owner, m_ptr;
    logic [31:0] m_a, m_b, m_q, m_r, m_hq, m_hr;
    logic        m_s;
    int          m_start_cyc, m_resp_cyc;

    // Divider stub
    bit          dv_busy = 1'b0;
    int          dv_rem, dv_lat_cfg = 3;
    logic [31:0] dv_q, dv_r;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic void ref_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                                    output logic [31:0] q, output logic [31:0] r);
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (s) begin
            q = 32'($signed(a) / $signed(b));
            r = 32'($signed(a) % $signed(b));
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    task automatic step();
        logic [N-1:0] exp_rdy, exp_ov;
        logic [31:0]  eq, er;
        int           win;
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            in_valid[i] = pend[i];
            in_dividend[32*i +: 32] = pend[i] ? ca[i] : $urandom;
            in_divisor[32*i +: 32]  = pend[i] ? cb[i] : $urandom;
            in_sign[i]              = pend[i] ? cs[i] : 1'($urandom);
        end
        out_ready = rdy_random ? N'($urandom) : rdy_mask;
        if (dv_busy) begin
            if (dv_rem == 0) begin
                div_done      = 1'b1;
                div_quotient  = dv_q;
                div_remainder = dv_r;
                dv_busy       = 1'b0;
                if (m_active && !m_zero && cyc > m_start_cyc && m_resp_cyc == INF)
                    m_resp_cyc = cyc + 1;
            end else begin
                div_done      = 1'b0;
                div_quotient  = $urandom;
                div_remainder = $urandom;
                dv_rem--;
            end
        end
        #1;
        win    = -1;
        exp_ov = '0;
        if (rst_n) begin
            exp_rdy = '0;
            if (!m_active) begin
                for (int k = 1; k <= N; k++) begin
                    int idx;
                    idx = (m_ptr + k) % N;
                    if (win < 0 && pend[idx]) win = idx;
                end
                if (win >= 0) exp_rdy[win] = 1'b1;
            end
            if (m_active && cyc >= m_resp_cyc) exp_ov[m_owner] = 1'b1;
            eq = (exp_ov != '0) ? m_q : m_hq;
            er = (exp_ov != '0) ? m_r : m_hr;
            check("busy", 32'(busy), 32'(m_active));
            check("in_ready", 32'(in_ready), 32'(exp_rdy));
            check("div_start", 32'(div_start), 32'(m_active && cyc == m_start_cyc));
            check("out_valid", 32'(out_valid), 32'(exp_ov));
            check("out_quotient", out_quotient, eq);
            check("out_remainder", out_remainder, er);
            if (m_active && !m_zero && cyc >= m_start_cyc && cyc < m_resp_cyc) begin
                check("div_dividend", div_dividend, m_a);
                check("div_divisor", div_divisor, m_b);
                check("div_sign", 32'(div_sign), 32'(m_s));
            end
        end
        if (!rst_n) begin
            m_active = 1'b0;
            m_ptr    = N - 1;
            m_hq     = '0;
            m_hr     = '0;
        end else begin
            if (div_start) begin
                start_cnt++;
                dv_busy = 1'b1;
                dv_rem  = (dv_lat_cfg > 0) ? dv_lat_cfg : $urandom_range(1, 6);
                ref_div(div_dividend, div_divisor, div_sign, dv_q, dv_r);
            end
            if (win >= 0) begin
                m_active    = 1'b1;
                m_owner     = win;
                m_ptr       = win;
                m_a         = ca[win];
                m_b         = cb[win];
                m_s         = cs[win];
                m_zero      = (cb[win] == 32'd0);
                ref_div(ca[win], cb[win], cs[win], m_q, m_r);
                m_start_cyc = m_zero ? -1 : cyc + 1;
                m_resp_cyc  = m_zero ? cyc + 2 : INF;
                pend[win]   = 1'b0;
                grants.push_back(win);
                last_acc_cyc = cyc;
            end else if (exp_ov != '0 && out_ready[m_owner]) begin
                resp_cnt[m_owner]++;
                resp_q[m_owner] = out_quotient;
                resp_r[m_owner] = out_remainder;
                m_hq     = m_q;
                m_hr     = m_r;
                m_active = 1'b0;
                last_resp_cyc = cyc;
            end
        end
        cyc++;
    endtask

    task automatic req(input int i, input logic [31:0] a, input logic [31:0] b, input logic s);
        pend[i] = 1'b1;
        ca[i]   = a;
        cb[i]   = b;
        cs[i]   = s;
    endtask

    task automatic arm_random(input int i);
        logic [31:0] a, b;
        logic        s;
        a = $urandom;
        if ($urandom_range(0, 3) == 0) a = $urandom_range(0, 200);
        case ($urandom_range(0, 7))
            0:       b = 32'd0;
            1, 2, 3: b = $urandom_range(1, 20);
            4:       b = ~32'($urandom_range(0, 19));
            default: b = $urandom;
        endcase
        s = 1'($urandom);
        if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd1;
        req(i, a, b, s);
    endtask

    task automatic wait_resp(input int i, input int bound);
        int c0, k;
        c0 = resp_cnt[i];
        k  = 0;
        while (resp_cnt[i] == c0 && k < bound) begin
            step();
            k++;
        end
        check("resp_timeout", 32'(resp_cnt[i] != c0), 32'd1);
    endtask

    task automatic drain(input int bound);
        int  k;
        bit  idle;
        k = 0;
        idle = 1'b0;
        while (!idle && k < bound) begin
            step();
            k++;
            idle = !m_active;
            for (int i = 0; i < N; i++) if (pend[i]) idle = 1'b0;
        end
        check("drain_timeout", 32'(idle), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0, g0, c2, k;
        int exp_order[6] = '{0, 1, 2, 3, 0, 1};
        rst_n = 1'b0;
        in_valid = '0; in_dividend = '0; in_divisor = '0; in_sign = '0;
        out_ready = '1;
        div_done = 1'b1; div_quotient = 32'h1234_5678; div_remainder = 32'h9abc_def0;
        for (int i = 0; i < N; i++) begin
            pend[i] = 1'b0; resp_cnt[i] = 0; resp_q[i] = '0; resp_r[i] = '0;
        end

        // Reset
        repeat (3) step();
        rst_n = 1'b1;
        step();
        check("rst_out_quotient", out_quotient, 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);

        // Unsigned 100/7 on client 0
        s0 = start_cnt;
        req(0, 32'd100, 32'd7, 1'b0);
        wait_resp(0, 40);
        check("u100_7_q", resp_q[0], 32'd14);
        check("u100_7_r", resp_r[0], 32'd2);
        check("u100_7_starts", 32'(start_cnt - s0), 32'd1);

        // Signed -100/7 on client 2
        req(2, 32'hFFFF_FF9C, 32'd7, 1'b1);
        wait_resp(2, 40);
        check("s100_7_q", resp_q[2], 32'hFFFF_FFF2);
        check("s100_7_r", resp_r[2], 32'hFFFF_FFFE);

        // Divide by zero on client 1, unsigned and signed
        s0 = start_cnt;
        req(1, 32'd5, 32'd0, 1'b0);
        wait_resp(1, 20);
        check("z5_q", resp_q[1], 32'hFFFF_FFFF);
        check("z5_r", resp_r[1], 32'd5);
        check("z5_lat", 32'(last_resp_cyc - last_acc_cyc), 32'd2);
        req(1, 32'hFFFF_FFFB, 32'd0, 1'b1);
        wait_resp(1, 20);
        check("zm5_r", resp_r[1], 32'hFFFF_FFFB);
        check("zero_starts", 32'(start_cnt - s0), 32'd0);

        // Round-robin from reset with all clients requesting
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        g0 = grants.size();
        for (int i = 0; i < N; i++) req(i, 32'(1000 + 17 * i), 32'(3 + i), 1'b0);
        k = 0;
        while (grants.size() < g0 + 6 && k < 300) begin
            step();
            k++;
            for (int i = 0; i < N; i++) if (!pend[i]) req(i, $urandom, 32'($urandom_range(1, 50)), 1'($urandom));
        end
        for (int j = 0; j < 6; j++)
            check("rr_order", (grants.size() > g0 + j) ? 32'(grants[g0 + j]) : 32'hDEAD, 32'(exp_order[j]));
        drain(200);

        // Backpressure on client 3 while others wait
        rdy_mask = '0;
        req(3, 32'd1000, 32'd33, 1'b0);
        step();
        req(0, 32'd50, 32'd5, 1'b0);
        req(1, 32'd60, 32'd6, 1'b0);
        k = 0;
        while (!out_valid[3] && k < 40) begin
            step();
            k++;
        end
        check("bp_reached_resp", 32'(out_valid[3]), 32'd1);
        repeat (10) step();
        rdy_mask = '1;
        step();
        step();
        check("bp_next_grant", 32'(last_acc_cyc), 32'(last_resp_cyc + 1));
        check("bp_q", resp_q[3], 32'd30);
        check("bp_r", resp_r[3], 32'd10);
        drain(200);

        // Reset while waiting on the divider
        dv_lat_cfg = 8;
        s0 = start_cnt;
        req(2, 32'd1234, 32'd5, 1'b0);
        k = 0;
        while (start_cnt == s0 && k < 20) begin
            step();
            k++;
        end
        step();
        step();
        c2 = resp_cnt[2];
        rst_n = 1'b0;
        req(3, 32'd77, 32'd7, 1'b0);
        req(0, 32'd81, 32'd9, 1'b0);
        step();
        @(posedge clk);
        #1;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_q", out_quotient, 32'd0);
        check("mid_rst_r", out_remainder, 32'd0);
        rst_n = 1'b1;
        g0 = grants.size();
        wait_resp(0, 40);
        check("mid_rst_first_grant", (grants.size() > g0) ? 32'(grants[g0]) : 32'hDEAD, 32'd0);
        check("mid_rst_81_9_q", resp_q[0], 32'd9);
        check("mid_rst_81_9_r", resp_r[0], 32'd0);
        drain(200);
        check("mid_rst_no_stale_resp", 32'(resp_cnt[2]), 32'(c2));

        // Random traffic
        dv_lat_cfg = 0;
        rdy_random = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) if (!pend[i] && $urandom_range(0, 2) == 0) arm_random(i);
            step();
        end
        rdy_random = 1'b0;
        rdy_mask   = '1;
        drain(400);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/dlsc_div32_arb.md
Name: dlsc_div32_arb

Overview:
- Shares one dlsc_div32 iterative divider between REQUESTERS independent clients.
- Arbitrates round-robin and issues the divider start pulse.
- Waits for divider completion, then returns quotient/remainder to the requester that owns the operation.
- Divide-by-zero is resolved locally without occupying the divider. Sits between client datapaths (e.g. CPU MDU, address generators) and the divider instance.

Parameters:
REQUESTERS, 4, number of clients (2..16)
IDB, $clog2(REQUESTERS), width of internal owner index (derived; not overridden)

Ports:
clk  in  1  clock; all logic on rising edge
rst_n  in  1  synchronous, active-low reset
in_valid  in  REQUESTERS  per-client request valid
in_ready  out  REQUESTERS  per-client accept (one-hot or zero)
in_dividend  in  32*REQUESTERS  flattened; client i at [32*i+:32]
in_divisor  in  32*REQUESTERS  flattened; client i at [32*i+:32]
in_sign  in  REQUESTERS  1 = signed operation for client i
out_valid  out  REQUESTERS  one-hot response valid
out_ready  in  REQUESTERS  per-client response accept
out_quotient  out  32  shared response quotient
out_remainder  out  32  shared response remainder
busy  out  1  high in any state but IDLE
div_dividend  out  32  to divider
div_divisor  out  32  to divider
div_sign  out  1  to divider
div_start  out  1  one-cycle start pulse to divider
div_done  in  1  divider idle/complete
div_quotient  in  32  divider result
div_remainder  in  32  divider result

Behaviour:
- Reset (rst_n low at clock edge):
  - state=IDLE; in_ready=0, out_valid=0, div_start=0, busy=0.
  - out_quotient/out_remainder=0; round-robin pointer last=REQUESTERS-1.
  - Reset mid-operation abandons the operation silently. The divider has no reset; it is not touched, and its stale div_done is ignored until this block next issues div_start.
- States:
  - IDLE -> START, or IDLE -> ZERO.
  - START -> WAIT1 -> WAIT -> RESP -> IDLE.
  - ZERO -> RESP.
- IDLE:
  - Winner g = first i with in_valid[i], scanning last+1, last+2, ... modulo REQUESTERS.
  - in_ready[g]=1 combinationally in that same cycle; ready depends on valid, and only one bit is ever set.
  - On acceptance: latch dividend, divisor, sign and owner=g; set last<=g.
  - Next state is ZERO if divisor==0, else START. No in_valid -> stay in IDLE.
- START:
  - div_start=1 for exactly this cycle; div_dividend/div_divisor/div_sign come from the latched operands and stay stable through WAIT.
- WAIT1:
  - Unconditional one-cycle guard; div_done is not sampled.
- WAIT:
  - When div_done=1, capture div_quotient/div_remainder into the output registers and go to RESP.
  - No timeout.
- ZERO:
  - Output registers <= quotient 32'hFFFFFFFF, remainder = latched dividend. This holds for both signed and unsigned.
  - div_start is never asserted.
- RESP:
  - out_valid[owner]=1; out_quotient/out_remainder stay stable.
  - When out_ready[owner]=1, return to IDLE; out_valid drops the next cycle.
  - out_ready on other bits is ignored. No new request is accepted until RESP completes (single outstanding op).
- Latency, with acceptance in cycle A:
  - div_start in A+1.
  - out_valid asserted exactly one cycle after the first WAIT cycle in which div_done=1.
  - Zero divisor: out_valid in A+2.
- Arithmetic: no special handling of signed overflow (-2^31 / -1); the result is whatever the divider produces. Sign is forwarded unmodified.
- Simultaneous events:
  - in_valid changing during non-IDLE states has no effect.
  - Requests that lose arbitration must hold; in_ready stays 0 for them.
  - Pointer fairness: a continuously requesting client is served within REQUESTERS grants.

Test Plan:
- Unsigned single op: client 0 requests 100/7, sign=0 -> div_start exactly once, one cycle after accept; out_valid[0] with q=14, r=2; busy is high from the cycle after accept until the response is accepted.
- Signed op on client 2: -100/7, sign=1 -> q=32'hFFFFFFF2, r=32'hFFFFFFFE; only out_valid[2] asserted.
- Divide-by-zero on client 1: 5/0 -> div_start never asserted; out_valid[1] two cycles after accept with q=32'hFFFFFFFF, r=5; same for signed -5/0 -> r=32'hFFFFFFFB.
- Round-robin: all four clients hold in_valid with distinct operands from reset -> grant order 0,1,2,3,0,1; each result matches its own operands.
- Backpressure: hold out_ready[owner]=0 for 10 cycles with other clients valid -> out_valid and data stable, in_ready stays 0, div_start not re-pulsed; release -> next grant follows in the IDLE cycle.
- Reset mid-operation: assert rst_n=0 for one cycle while in WAIT -> all outputs at reset values, pointer reset (client 0 wins next); a subsequent 81/9 returns q=9, r=0 with no response from the aborted op.
